booth2_mul_adder_arb: RTL and testbench
=======================================

Name: booth2_mul_adder_arb

Overview:
- Round-robin arbiter and scheduler that shares one registered DATA_THR-bit carry-lookahead adder between REQ_NUM requesters.
- Requesters are the partial-product compression and final-sum stages of the booth2 multiplier.
- Issues one add per cycle to the shared adder.
- Tracks the requester ID of every in-flight add through a tag delay line, and routes each adder result back to its owner.

Parameters:
- DATA_THR, 32, operand and sum width; multiple of 4.
- REQ_NUM, 3, number of requesters; 2..8.
- ADD_LAT, 1, adder latency in cycles from add_val_o to add_val_i; 1..4.
- ID_WD, 3, tag width; must satisfy 2^ID_WD >= REQ_NUM.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_val_i  in  REQ_NUM  per-requester request valid.
- req_a_i  in  REQ_NUM*DATA_THR  operand A; slice k belongs to requester k.
- req_b_i  in  REQ_NUM*DATA_THR  operand B; slice k belongs to requester k.
- req_gnt_o  out  REQ_NUM  one-hot grant; operands are consumed in the same cycle.
- add_val_o  out  1  issue valid to the adder.
- add_a_o  out  DATA_THR  adder operand A.
- add_b_o  out  DATA_THR  adder operand B.
- add_val_i  in  1  adder result valid.
- add_so_i  in  DATA_THR  adder sum.
- add_cout_i  in  1  adder carry-out.
- rsp_val_o  out  REQ_NUM  one-hot response valid.
- rsp_so_o  out  DATA_THR  response sum, shared bus.
- rsp_cout_o  out  1  response carry-out.
- busy_o  out  1  high while any add is issued or in flight.
- err_o  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset: all outputs, registered state and round-robin pointer go to 0 immediately on rst, independent of clk.
  - Reset mid-operation discards all in-flight tags.
  - Adder results arriving after reset deassertion produce no response.
- Arbitration (combinational within cycle t):
  - Search starts at pointer ptr and proceeds upward, wrapping from REQ_NUM-1 to 0.
  - The first k with req_val_i[k] gets req_gnt_o[k]=1. At most one grant per cycle.
  - No grant when req_val_i=0.
- Pointer update at the edge ending cycle t:
  - On a grant to k: ptr <= (k+1) mod REQ_NUM.
  - Without a grant: ptr holds.
- Issue: at the edge ending cycle t, add_val_o<=1, add_a_o<=req_a_i slice k, add_b_o<=req_b_i slice k, tag<=k.
  - Cycles without a grant: add_val_o<=0; add_a_o and add_b_o hold their last values.
- Tag line:
  - Shift register of ADD_LAT stages, each stage {valid, ID}.
  - Stage 0 is loaded from the issued tag.
  - The last stage aligns with add_val_i, so a result arrives in cycle t+1+ADD_LAT.
- Response (combinational from add_val_i and the last tag stage):
  - rsp_val_o[id]=add_val_i & tag_valid.
  - rsp_so_o=add_so_i; rsp_cout_o=add_cout_i.
  - Grant-to-response latency is 1+ADD_LAT cycles; throughput is 1 add per cycle.
  - Responses have no backpressure; requesters must accept them.
- A requester holding req_val_i continuously is granted at most once every REQ_NUM cycles when all requesters are active.
- busy_o = add_val_o | OR of all tag-stage valids.
- Operands are forwarded unchanged. The adder's cin is tied 0 outside this block.

Optional Feature:
- Macro: BOOTH2_MUL_ADD_ARB_CHK_EN.
- When defined:
  - err_o sets on add_val_i=1 with last tag invalid.
  - err_o also sets on add_val_i=0 with last tag valid.
  - Once set, err_o stays set until rst.
- When not defined: err_o is tied 0 and no checker logic is built.

Decomposition:
- Shared package booth2_mul_pkg holds:
  - BASIC_ADDER_WD=4.
  - Default DATA_THR, REQ_NUM and ADD_LAT.
  - The tag struct {valid, id[ID_WD]}.
- One sub-module: booth2_mul_rr_picker.
  - Combinational round-robin one-hot select from req_val_i and ptr.
  - Outputs grant vector and encoded ID.

Test Plan (DATA_THR=32, REQ_NUM=3, ADD_LAT=1):
- Single request:
  - Stimulus: req_val_i=001, A=0x0000_0005, B=0x0000_0007.
  - Response: req_gnt_o=001 in cycle 0; add_val_o=1 in cycle 1; in cycle 2 rsp_val_o=001, rsp_so_o=0x0000_000C, rsp_cout_o=0.
- All three requesting continuously:
  - Grants rotate 001,010,100,001.
  - Responses follow the same order, 2 cycles later.
  - No gaps in add_val_o.
- Carry-out:
  - Stimulus: requester 2 adds A=0xFFFF_FFFF, B=0x0000_0001.
  - Response: rsp_val_o=100, rsp_so_o=0x0000_0000, rsp_cout_o=1.
- Pointer hold:
  - Stimulus: grant to requester 1, then 3 idle cycles, then req_val_i=011.
  - Response: requester 0 is granted first (ptr=2 wraps to 0).
- Reset mid-flight:
  - Stimulus: assert rst one cycle after a grant.
  - Response: all outputs 0 asynchronously; after release, the pending add_val_i produces rsp_val_o=000 and busy_o=0.
- With BOOTH2_MUL_ADD_ARB_CHK_EN:
  - Stimulus: force add_val_i=1 while idle.
  - Response: err_o=1 from the next cycle and stays 1 until rst.

Source files
------------

// File: rtl/booth2_mul_pkg.sv
// Shared definitions for the booth2 multiplier adder-sharing logic:
// default geometry of the shared adder and the in-flight tag record.
package booth2_mul_pkg;

    localparam int BASIC_ADDER_WD = 4;
    localparam int DEF_DATA_THR   = 32;
    localparam int DEF_REQ_NUM    = 3;
    localparam int DEF_ADD_LAT    = 1;
    localparam int DEF_ID_WD      = 3;

    // One in-flight add: whether the slot holds an add, and who owns it.
    typedef struct packed {
        logic                 valid;
        logic [DEF_ID_WD-1:0] id;
    } tag_t;

endpackage

// File: rtl/booth2_mul_rr_picker.sv
// Combinational round-robin picker: starting at ptr and wrapping, selects
// the first active requester and returns a one-hot grant plus its index.
module booth2_mul_rr_picker #(
    parameter int REQ_NUM = 3,
    parameter int ID_WD   = 3
) (
    input  logic [REQ_NUM-1:0] req_val,
    input  logic [ID_WD-1:0]   ptr,
    output logic [REQ_NUM-1:0] gnt,
    output logic [ID_WD-1:0]   gnt_id,
    output logic               gnt_any
);

    int idx;

    // Scan requesters from ptr upward, keeping only the first hit.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            idx = (int'(ptr) + i) % REQ_NUM;
            if (!gnt_any && req_val[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = ID_WD'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth2_mul_adder_arb.sv
// Round-robin scheduler sharing one registered adder between several
// booth2 requesters. Issues at most one add per cycle, carries the owner ID
// of each add through a tag delay line, and steers results back.
// Optional protocol checker: define BOOTH2_MUL_ADD_ARB_CHK_EN.
module booth2_mul_adder_arb
    import booth2_mul_pkg::*;
#(
    parameter int DATA_THR = DEF_DATA_THR,
    parameter int REQ_NUM  = DEF_REQ_NUM,
    parameter int ADD_LAT  = DEF_ADD_LAT,
    parameter int ID_WD    = DEF_ID_WD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REQ_NUM-1:0]          req_val_i,
    input  logic [REQ_NUM*DATA_THR-1:0] req_a_i,
    input  logic [REQ_NUM*DATA_THR-1:0] req_b_i,
    output logic [REQ_NUM-1:0]          req_gnt_o,
    output logic                        add_val_o,
    output logic [DATA_THR-1:0]         add_a_o,
    output logic [DATA_THR-1:0]         add_b_o,
    input  logic                        add_val_i,
    input  logic [DATA_THR-1:0]         add_so_i,
    input  logic                        add_cout_i,
    output logic [REQ_NUM-1:0]          rsp_val_o,
    output logic [DATA_THR-1:0]         rsp_so_o,
    output logic                        rsp_cout_o,
    output logic                        busy_o,
    output logic                        err_o
);

    logic [ID_WD-1:0] ptr;
    logic [ID_WD-1:0] gnt_id;
    logic             gnt_any;
    logic [ID_WD-1:0] issue_id;
    tag_t             tag_q [ADD_LAT];
    tag_t             last_tag;

    booth2_mul_rr_picker #(
        .REQ_NUM (REQ_NUM),
        .ID_WD   (ID_WD)
    ) u_picker (
        .req_val (req_val_i),
        .ptr     (ptr),
        .gnt     (req_gnt_o),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    // Advance the round-robin pointer past the winner; hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_id == ID_WD'(REQ_NUM - 1)) ? '0 : gnt_id + ID_WD'(1);
        end
    end

    // Launch the winner's operands; operands hold when nothing is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_val_o <= 1'b0;
            add_a_o   <= '0;
            add_b_o   <= '0;
            issue_id  <= '0;
        end else begin
            add_val_o <= gnt_any;
            if (gnt_any) begin
                add_a_o  <= req_a_i[gnt_id*DATA_THR +: DATA_THR];
                add_b_o  <= req_b_i[gnt_id*DATA_THR +: DATA_THR];
                issue_id <= gnt_id;
            end
        end
    end

    // Delay the owner tag so the last stage lines up with the adder result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ADD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0].valid <= add_val_o;
            tag_q[0].id    <= DEF_ID_WD'(issue_id);
            for (int k = 1; k < ADD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign last_tag   = tag_q[ADD_LAT-1];
    assign rsp_so_o   = add_so_i;
    assign rsp_cout_o = add_cout_i;

    // Steer a valid result to the requester recorded in the last tag stage.
    always_comb begin
        rsp_val_o = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            rsp_val_o[k] = add_val_i & last_tag.valid
                           & (last_tag.id == DEF_ID_WD'(k));
        end
    end

    // Busy while anything is being issued or still inside the adder.
    always_comb begin
        busy_o = add_val_o;
        for (int k = 0; k < ADD_LAT; k++) begin
            busy_o = busy_o | tag_q[k].valid;
        end
    end

`ifdef BOOTH2_MUL_ADD_ARB_CHK_EN
    logic err_q;

    // Sticky flag when the adder's valid disagrees with the tag line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (add_val_i != last_tag.valid) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_booth2_mul_adder_arb.sv
// Scoreboard bench for booth2_mul_adder_arb (32-bit, 3 requesters, latency 1).
// The bench plays the shared adder and predicts grants and responses.
module tb_booth2_mul_adder_arb;

    localparam int DW = 32;
    localparam int RN = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [RN-1:0]   req_val_i;
    logic [RN*DW-1:0] req_a_i;
    logic [RN*DW-1:0] req_b_i;
    logic [RN-1:0]   req_gnt_o;
    logic            add_val_o;
    logic [DW-1:0]   add_a_o;
    logic [DW-1:0]   add_b_o;
    logic            add_val_i;
    logic [DW-1:0]   add_so_i;
    logic            add_cout_i;
    logic [RN-1:0]   rsp_val_o;
    logic [DW-1:0]   rsp_so_o;
    logic            rsp_cout_o;
    logic            busy_o;
    logic            err_o;

    booth2_mul_adder_arb #(
        .DATA_THR (DW),
        .REQ_NUM  (RN),
        .ADD_LAT  (1),
        .ID_WD    (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_val_i  (req_val_i),
        .req_a_i    (req_a_i),
        .req_b_i    (req_b_i),
        .req_gnt_o  (req_gnt_o),
        .add_val_o  (add_val_o),
        .add_a_o    (add_a_o),
        .add_b_o    (add_b_o),
        .add_val_i  (add_val_i),
        .add_so_i   (add_so_i),
        .add_cout_i (add_cout_i),
        .rsp_val_o  (rsp_val_o),
        .rsp_so_o   (rsp_so_o),
        .rsp_cout_o (rsp_cout_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          id;
        logic [DW-1:0] sum;
        logic        cout;
    } sbEntry_t;

    sbEntry_t sbQueue[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mPtr = 0;
    logic gHist1 = 1'b0;
    logic gHist2 = 1'b0;
    logic advVal = 1'b0;
    logic [DW-1:0] advSum = '0;
    logic advCout = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one cycle of requests, then check grants/issue/responses mid-cycle.
    task automatic applyStimulus(input logic [RN-1:0] val, input logic [RN*DW-1:0] a,
                                 input logic [RN*DW-1:0] b);
        logic [RN-1:0] expGnt;
        logic [RN-1:0] expRsp;
        logic [DW:0]   full;
        int            win;
        sbEntry_t      e;
        req_val_i  = val;
        req_a_i    = a;
        req_b_i    = b;
        add_val_i  = advVal;
        add_so_i   = advSum;
        add_cout_i = advCout;
        @(negedge clk);
        expGnt = '0;
        win    = -1;
        for (int i = 0; i < RN; i++) begin
            if (win < 0 && val[(mPtr + i) % RN]) win = (mPtr + i) % RN;
        end
        if (win >= 0) begin
            expGnt[win] = 1'b1;
            full   = {1'b0, a[win*DW +: DW]} + {1'b0, b[win*DW +: DW]};
            e.due  = cyc + 2;
            e.id   = win;
            e.sum  = full[DW-1:0];
            e.cout = full[DW];
            sbQueue.push_back(e);
            mPtr = (win + 1) % RN;
        end
        checkOutput("gnt", 64'(req_gnt_o), 64'(expGnt));
        checkOutput("addVal", 64'(add_val_o), 64'(gHist1));
        checkOutput("busy", 64'(busy_o), 64'(gHist1 | gHist2));
        expRsp = '0;
        if (sbQueue.size() > 0 && sbQueue[0].due == cyc) begin
            e = sbQueue.pop_front();
            expRsp[e.id] = 1'b1;
            checkOutput("rspSo", 64'(rsp_so_o), 64'(e.sum));
            checkOutput("rspCout", 64'(rsp_cout_o), 64'(e.cout));
        end
        checkOutput("rspVal", 64'(rsp_val_o), 64'(expRsp));
        checkOutput("err", 64'(err_o), 64'd0);
        advVal = add_val_o;
        full   = {1'b0, add_a_o} + {1'b0, add_b_o};
        advSum = full[DW-1:0];
        advCout = full[DW];
        gHist2 = gHist1;
        gHist1 = (win >= 0);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, '0);
    endtask

    initial begin
        rst = 1'b1;
        req_val_i = '0; req_a_i = '0; req_b_i = '0;
        add_val_i = 1'b0; add_so_i = '0; add_cout_i = 1'b0;
        #1;
        checkOutput("rstAddVal", 64'(add_val_o), 64'd0);
        checkOutput("rstBusy", 64'(busy_o), 64'd0);
        checkOutput("rstRsp", 64'(rsp_val_o), 64'd0);
        checkOutput("rstGnt", 64'(req_gnt_o), 64'd0);
        checkOutput("rstErr", 64'(err_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single request: 5 + 7 from requester 0.
        applyStimulus(3'b001, {32'd0, 32'd0, 32'h5}, {32'd0, 32'd0, 32'h7});
        idle(3);

        // All three requesting back to back.
        for (int i = 0; i < 6; i++)
            applyStimulus(3'b111, {32'h3000_0000 + i, 32'h2000_0000 + i, 32'h1000_0000 + i},
                          {32'h0300_0000, 32'h0200_0000, 32'h0100_0000 + i});
        idle(3);

        // Carry-out from requester 2.
        applyStimulus(3'b100, {32'hFFFF_FFFF, 64'd0}, {32'h0000_0001, 64'd0});
        idle(3);

        // Pointer hold: grant 1, idle, then 0 and 1 compete.
        applyStimulus(3'b010, {32'd0, 32'h11, 32'd0}, {32'd0, 32'h22, 32'd0});
        idle(3);
        applyStimulus(3'b011, {32'd0, 32'h40, 32'h80}, {32'd0, 32'h1, 32'h2});
        checkOutput("ptrWrapFirst", 64'(sbQueue[0].id), 64'd0);
        applyStimulus(3'b011, {32'd0, 32'h40, 32'h80}, {32'd0, 32'h1, 32'h2});
        idle(3);

        // Random traffic.
        for (int i = 0; i < 24; i++)
            applyStimulus(RN'($urandom_range(0, 7)),
                          {$urandom(), $urandom(), $urandom()},
                          {$urandom(), $urandom(), $urandom()});
        idle(3);
        checkOutput("sbEmpty", 64'(sbQueue.size()), 64'd0);

        // Reset one cycle after a grant discards the in-flight add.
        applyStimulus(3'b001, {64'd0, 32'h9}, {64'd0, 32'h9});
        checkOutput("preRstBusy", 64'(busy_o), 64'd1);
        req_val_i = '0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncAddVal", 64'(add_val_o), 64'd0);
        checkOutput("asyncAddA", 64'(add_a_o), 64'd0);
        checkOutput("asyncBusy", 64'(busy_o), 64'd0);
        checkOutput("asyncRsp", 64'(rsp_val_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        add_val_i = 1'b1;
        add_so_i  = 32'h12;
        #1;
        checkOutput("lateRsp", 64'(rsp_val_o), 64'd0);
        checkOutput("lateBusy", 64'(busy_o), 64'd0);
        @(posedge clk);
        #1;
        add_val_i = 1'b0;
`ifdef BOOTH2_MUL_ADD_ARB_CHK_EN
        checkOutput("errSet", 64'(err_o), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("errSticky", 64'(err_o), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("errClear", 64'(err_o), 64'd0);
        rst = 1'b0;
`else
        checkOutput("errTied", 64'(err_o), 64'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
